qdma_stm_h2c_hdr_strip: RTL and testbench

Fabric-side consumer of the H2C streaming stub output. It accepts the per-packet stream (one header beat flagged by `tuser`, then payload beats ending in `tlast`) and decodes the header into per-packet sideband. It forwards only the payload through a registered output stage and emits one packet-summary record per packet. It sits directly downstream of the H2C stub, in front of the user/loopback logic.

---
 rtl/qdma_stm_h2c_hdr_strip_if.sv | 47 ++++
 rtl/qdma_stm_h2c_hdr_strip.sv | 232 +++++++++++++++++++++++
 tb/tb_qdma_stm_h2c_hdr_strip.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qdma_stm_h2c_hdr_strip_if.sv
// Signal bundle around qdma_stm_h2c_hdr_strip: the H2C input stream, the stripped
// payload stream with its per-packet sideband, and the packet-summary record.
interface qdma_stm_h2c_hdr_strip_if #(
   parameter int MAX_DATA_WIDTH = 512,
   parameter int TDEST_BITS     = 16,
   parameter int QID_BITS       = 11,
   parameter int BCNT_BITS      = 16
);
   logic [MAX_DATA_WIDTH-1:0] in_axis_tdata;
   logic                      in_axis_tvalid;
   logic                      in_axis_tready;
   logic [TDEST_BITS-1:0]     in_axis_tdest;
   logic                      in_axis_tuser;
   logic                      in_axis_tlast;

   logic [MAX_DATA_WIDTH-1:0] out_axis_tdata;
   logic                      out_axis_tvalid;
   logic                      out_axis_tready;
   logic                      out_axis_tlast;
   logic [QID_BITS-1:0]       out_axis_qid;
   logic [31:0]               out_axis_mdata;

   logic                      sum_vld;
   logic                      sum_rdy;
   logic [QID_BITS-1:0]       sum_qid;
   logic [BCNT_BITS-1:0]      sum_beats;
   logic                      sum_err;
   logic [15:0]               drop_cnt;

   modport master (
      output in_axis_tdata, in_axis_tvalid, in_axis_tdest, in_axis_tuser, in_axis_tlast,
      input  in_axis_tready,
      input  out_axis_tdata, out_axis_tvalid, out_axis_tlast, out_axis_qid, out_axis_mdata,
      output out_axis_tready,
      input  sum_vld, sum_qid, sum_beats, sum_err, drop_cnt,
      output sum_rdy
   );

   modport slave (
      input  in_axis_tdata, in_axis_tvalid, in_axis_tdest, in_axis_tuser, in_axis_tlast,
      output in_axis_tready,
      output out_axis_tdata, out_axis_tvalid, out_axis_tlast, out_axis_qid, out_axis_mdata,
      input  out_axis_tready,
      output sum_vld, sum_qid, sum_beats, sum_err, drop_cnt,
      input  sum_rdy
   );
endinterface

// File: rtl/qdma_stm_h2c_hdr_strip.sv
// Strips the H2C stub header beat, forwards payload with qid/mdata sideband and emits one
// summary per packet. Optional tdest/qid consistency check: QDMA_H2C_STRIP_TDEST_CHK_EN.
module qdma_stm_h2c_hdr_strip #(
   parameter int MAX_DATA_WIDTH = 512,
   parameter int TDEST_BITS     = 16,
   parameter int QID_BITS       = 11,
   parameter int BCNT_BITS      = 16,
   parameter int TCQ            = 0
) (
   input logic                     clk,
   input logic                     rst_n,
   qdma_stm_h2c_hdr_strip_if.slave bus
);

   // Header beat layout of h2c_stub_hdr_beat_t: qid in the low bits, cdh_slot_0.tmh in [63:32].
   typedef struct packed {
      logic [31:0] tmh;
   } cdh_slot_t;

   typedef struct packed {
      logic [MAX_DATA_WIDTH-65:0] rsvd_hi;
      cdh_slot_t                  cdh_slot_0;
      logic [31-QID_BITS:0]       rsvd_lo;
      logic [QID_BITS-1:0]        qid;
   } h2c_stub_hdr_beat_t;

   typedef enum logic [0:0] {
      S_HDR = 1'b0,
      S_PLD = 1'b1
   } state_t;

   state_t                    state_r;
   state_t                    state_nxt_s;
   h2c_stub_hdr_beat_t        hdr_s;

   logic [QID_BITS-1:0]       qid_r;
   logic [QID_BITS-1:0]       qid_nxt_s;
   logic [31:0]               mdata_r;
   logic [31:0]               mdata_nxt_s;
   logic [BCNT_BITS-1:0]      bcnt_r;
   logic [BCNT_BITS-1:0]      bcnt_nxt_s;
   logic [BCNT_BITS-1:0]      bcnt_inc_s;
   logic                      err_r;
   logic                      err_nxt_s;

   logic                      tready_s;
   logic                      out_free_s;
   logic                      sum_free_s;
   logic                      tdest_err_s;
   logic                      out_load_s;
   logic                      sum_load_s;
   logic                      drop_s;
   logic [QID_BITS-1:0]       sum_qid_nxt_s;
   logic [BCNT_BITS-1:0]      sum_beats_nxt_s;
   logic                      sum_err_nxt_s;

   logic [MAX_DATA_WIDTH-1:0] out_tdata_r;
   logic                      out_tvalid_r;
   logic                      out_tlast_r;
   logic [QID_BITS-1:0]       out_qid_r;
   logic [31:0]               out_mdata_r;

   logic                      sum_vld_r;
   logic [QID_BITS-1:0]       sum_qid_r;
   logic [BCNT_BITS-1:0]      sum_beats_r;
   logic                      sum_err_r;
   logic [15:0]               drop_cnt_r;

   logic                      unused_s;

   assign hdr_s      = h2c_stub_hdr_beat_t'(bus.in_axis_tdata);
   assign out_free_s = !out_tvalid_r || bus.out_axis_tready;
   assign sum_free_s = !sum_vld_r || bus.sum_rdy;
   assign bcnt_inc_s = (&bcnt_r) ? bcnt_r : (bcnt_r + {{(BCNT_BITS-1){1'b0}}, 1'b1});

`ifdef QDMA_H2C_STRIP_TDEST_CHK_EN
   assign tdest_err_s = (bus.in_axis_tdest[5:0] != qid_r[5:0]);
   assign unused_s    = ^{hdr_s.rsvd_hi, hdr_s.rsvd_lo, bus.in_axis_tdest[TDEST_BITS-1:6], TCQ[0]};
`else
   assign tdest_err_s = 1'b0;
   assign unused_s    = ^{hdr_s.rsvd_hi, hdr_s.rsvd_lo, bus.in_axis_tdest, TCQ[0]};
`endif

   // Next-state, input ready and per-beat actions.
   always_comb begin
      state_nxt_s     = state_r;
      qid_nxt_s       = qid_r;
      mdata_nxt_s     = mdata_r;
      bcnt_nxt_s      = bcnt_r;
      err_nxt_s       = err_r;
      tready_s        = 1'b0;
      out_load_s      = 1'b0;
      sum_load_s      = 1'b0;
      drop_s          = 1'b0;
      sum_qid_nxt_s   = qid_r;
      sum_beats_nxt_s = bcnt_r;
      sum_err_nxt_s   = err_r;
      case (state_r)
         S_HDR: begin
            // An empty packet writes its summary immediately, so it needs the slot free.
            if (bus.in_axis_tuser && bus.in_axis_tlast) begin
               tready_s = sum_free_s;
            end else begin
               tready_s = 1'b1;
            end
            if (bus.in_axis_tvalid && tready_s) begin
               if (bus.in_axis_tuser) begin
                  qid_nxt_s   = hdr_s.qid;
                  mdata_nxt_s = hdr_s.cdh_slot_0.tmh;
                  bcnt_nxt_s  = {BCNT_BITS{1'b0}};
                  err_nxt_s   = 1'b0;
                  if (bus.in_axis_tlast) begin
                     sum_load_s      = 1'b1;
                     sum_qid_nxt_s   = hdr_s.qid;
                     sum_beats_nxt_s = {BCNT_BITS{1'b0}};
                     sum_err_nxt_s   = 1'b1;
                  end else begin
                     state_nxt_s = S_PLD;
                  end
               end else begin
                  drop_s = 1'b1;
               end
            end else begin
               drop_s = 1'b0;
            end
         end
         S_PLD: begin
            tready_s = out_free_s && (!bus.in_axis_tlast || sum_free_s);
            if (bus.in_axis_tvalid && tready_s) begin
               out_load_s = 1'b1;
               bcnt_nxt_s = bcnt_inc_s;
               err_nxt_s  = err_r || bus.in_axis_tuser || tdest_err_s;
               if (bus.in_axis_tlast) begin
                  sum_load_s      = 1'b1;
                  sum_qid_nxt_s   = qid_r;
                  sum_beats_nxt_s = bcnt_inc_s;
                  sum_err_nxt_s   = err_nxt_s;
                  state_nxt_s     = S_HDR;
               end else begin
                  sum_load_s = 1'b0;
               end
            end else begin
               out_load_s = 1'b0;
            end
         end
         default: begin
            state_nxt_s = S_HDR;
         end
      endcase
   end

   // FSM state and per-packet context.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_HDR;
         qid_r   <= {QID_BITS{1'b0}};
         mdata_r <= 32'h0000_0000;
         bcnt_r  <= {BCNT_BITS{1'b0}};
         err_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         qid_r   <= qid_nxt_s;
         mdata_r <= mdata_nxt_s;
         bcnt_r  <= bcnt_nxt_s;
         err_r   <= err_nxt_s;
      end
   end

   // Payload output register; holds data while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_tdata_r  <= {MAX_DATA_WIDTH{1'b0}};
         out_tvalid_r <= 1'b0;
         out_tlast_r  <= 1'b0;
         out_qid_r    <= {QID_BITS{1'b0}};
         out_mdata_r  <= 32'h0000_0000;
      end else if (out_load_s) begin
         out_tdata_r  <= bus.in_axis_tdata;
         out_tvalid_r <= 1'b1;
         out_tlast_r  <= bus.in_axis_tlast;
         out_qid_r    <= qid_r;
         out_mdata_r  <= mdata_r;
      end else if (bus.out_axis_tready) begin
         out_tvalid_r <= 1'b0;
      end else begin
         out_tvalid_r <= out_tvalid_r;
      end
   end

   // Single-entry summary slot; a new record may replace one consumed this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_vld_r   <= 1'b0;
         sum_qid_r   <= {QID_BITS{1'b0}};
         sum_beats_r <= {BCNT_BITS{1'b0}};
         sum_err_r   <= 1'b0;
      end else if (sum_load_s) begin
         sum_vld_r   <= 1'b1;
         sum_qid_r   <= sum_qid_nxt_s;
         sum_beats_r <= sum_beats_nxt_s;
         sum_err_r   <= sum_err_nxt_s;
      end else if (bus.sum_rdy) begin
         sum_vld_r <= 1'b0;
      end else begin
         sum_vld_r <= sum_vld_r;
      end
   end

   // Saturating count of beats dropped outside a packet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_r <= 16'h0000;
      end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
         drop_cnt_r <= drop_cnt_r + 16'h0001;
      end else begin
         drop_cnt_r <= drop_cnt_r;
      end
   end

   assign bus.in_axis_tready  = tready_s;
   assign bus.out_axis_tdata  = out_tdata_r;
   assign bus.out_axis_tvalid = out_tvalid_r;
   assign bus.out_axis_tlast  = out_tlast_r;
   assign bus.out_axis_qid    = out_qid_r;
   assign bus.out_axis_mdata  = out_mdata_r;
   assign bus.sum_vld         = sum_vld_r;
   assign bus.sum_qid         = sum_qid_r;
   assign bus.sum_beats       = sum_beats_r;
   assign bus.sum_err         = sum_err_r;
   assign bus.drop_cnt        = drop_cnt_r;

endmodule

// File: tb/tb_qdma_stm_h2c_hdr_strip.sv
// Bench for qdma_stm_h2c_hdr_strip: table of directed packets, hand-written corner sequences
// and randomized traffic, all checked against a packet-level reference model.
module tb_qdma_stm_h2c_hdr_strip;
   localparam int DW  = 512;
   localparam int TDW = 16;
   localparam int QW  = 11;
   localparam int BW  = 16;
`ifdef QDMA_H2C_STRIP_TDEST_CHK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   typedef struct {
      logic [DW-1:0]  data;
      logic           tuser;
      logic           tlast;
      logic [TDW-1:0] tdest;
   } beat_t;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          tlast;
      logic [QW-1:0] qid;
      logic [31:0]   mdata;
   } obeat_t;

   typedef struct packed {
      logic [QW-1:0] qid;
      logic [BW-1:0] beats;
      logic          err;
   } sum_t;

   typedef struct {
      logic [QW-1:0] qid;
      logic [31:0]   mdata;
      int            npld;
      int            pld_mode;   // 0 normal, 1 tdest mismatch, 2 tuser on 2nd payload beat
      int            ordy_mode;  // 0 always ready, 1 toggle, 2 random
      logic [BW-1:0] exp_beats;
      logic          exp_err;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   qdma_stm_h2c_hdr_strip_if #(.MAX_DATA_WIDTH(DW), .TDEST_BITS(TDW), .QID_BITS(QW), .BCNT_BITS(BW)) bus ();

   qdma_stm_h2c_hdr_strip #(.MAX_DATA_WIDTH(DW), .TDEST_BITS(TDW), .QID_BITS(QW), .BCNT_BITS(BW), .TCQ(0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   beat_t  in_q[$];
   obeat_t got_out[$];
   obeat_t exp_out[$];
   sum_t   got_sum[$];
   sum_t   exp_sum[$];
   int     in_cyc[$];
   int     out_cyc[$];
   int     sum_cyc[$];
   vec_t   tbl[6];

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int run_base = 0;
   int ordy_mode = 0;
   int srdy_mode = 0;
   int srdy_hold = 0;
   bit vld_gap = 1'b0;
   bit stall_seen = 1'b0;

   // packet-level reference model state
   bit            m_in_pkt = 1'b0;
   logic [QW-1:0] m_qid;
   logic [31:0]   m_mdata;
   int            m_cnt;
   bit            m_err;
   int            m_drops = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
      return d;
   endfunction

   task automatic model_beat(input beat_t b);
      obeat_t o;
      sum_t   s;
      if (!m_in_pkt) begin
         if (b.tuser) begin
            m_qid = b.data[QW-1:0]; m_mdata = b.data[63:32]; m_cnt = 0; m_err = 1'b0;
            if (b.tlast) begin
               s.qid = m_qid; s.beats = '0; s.err = 1'b1; exp_sum.push_back(s);
            end else m_in_pkt = 1'b1;
         end else if (m_drops < 65535) m_drops++;
      end else begin
         o.data = b.data; o.tlast = b.tlast; o.qid = m_qid; o.mdata = m_mdata;
         exp_out.push_back(o);
         if (m_cnt < (1 << BW) - 1) m_cnt++;
         if (b.tuser || (CHK && (b.tdest[5:0] != m_qid[5:0]))) m_err = 1'b1;
         if (b.tlast) begin
            s.qid = m_qid; s.beats = BW'(m_cnt); s.err = m_err; exp_sum.push_back(s);
            m_in_pkt = 1'b0;
         end
      end
   endtask

   task automatic push_beat(input beat_t b);
      in_q.push_back(b);
      model_beat(b);
   endtask

   task automatic add_pkt(input logic [QW-1:0] qid, input logic [31:0] mdata, input int npld, input int pld_mode);
      beat_t b;
      b.data = rand_data(); b.data[QW-1:0] = qid; b.data[63:32] = mdata;
      b.tuser = 1'b1; b.tlast = (npld == 0); b.tdest = TDW'(qid[5:0]);
      push_beat(b);
      for (int i = 0; i < npld; i++) begin
         b.data  = rand_data();
         b.tuser = (pld_mode == 2) && (i == 1);
         b.tlast = (i == npld - 1);
         b.tdest = (pld_mode == 1) ? 16'h0002 : TDW'(qid[5:0]);
         push_beat(b);
      end
   endtask

   task automatic clear_all();
      got_out.delete(); exp_out.delete(); got_sum.delete(); exp_sum.delete();
      in_cyc.delete(); out_cyc.delete(); sum_cyc.delete();
   endtask

   // Drives queued beats and ready patterns, records every handshake, checks output stability.
   task automatic run(input int max_cyc);
      int     n = 0;
      int     idle = 0;
      bit     in_pend = 1'b0;
      bit     o_stall = 1'b0;
      bit     s_stall = 1'b0;
      obeat_t po;
      sum_t   ps;
      obeat_t o;
      sum_t   s;
      run_base = cyc;
      while (idle < 3 && n < max_cyc) begin
         @(negedge clk);
         if (in_q.size() > 0 && (in_pend || !vld_gap || $urandom_range(0, 3) != 0)) begin
            bus.in_axis_tvalid = 1'b1; bus.in_axis_tdata = in_q[0].data;
            bus.in_axis_tuser = in_q[0].tuser; bus.in_axis_tlast = in_q[0].tlast;
            bus.in_axis_tdest = in_q[0].tdest;
         end else begin
            bus.in_axis_tvalid = 1'b0; bus.in_axis_tuser = 1'b0; bus.in_axis_tlast = 1'b0;
         end
         if (ordy_mode == 0) bus.out_axis_tready = 1'b1;
         else if (ordy_mode == 1) bus.out_axis_tready = cyc[0];
         else bus.out_axis_tready = 1'($urandom_range(0, 1));
         if (srdy_mode == 0) bus.sum_rdy = 1'b1;
         else if (srdy_mode == 2) bus.sum_rdy = 1'($urandom_range(0, 1));
         else bus.sum_rdy = (n >= srdy_hold);
         #2;
         o.data = bus.out_axis_tdata; o.tlast = bus.out_axis_tlast;
         o.qid = bus.out_axis_qid; o.mdata = bus.out_axis_mdata;
         s.qid = bus.sum_qid; s.beats = bus.sum_beats; s.err = bus.sum_err;
         if (o_stall) begin
            total++;
            if (!bus.out_axis_tvalid || o !== po) begin
               bad++;
               $display("FAIL out_hold: cycle %0d tvalid=%b data changed=%b, required held", cyc, bus.out_axis_tvalid, o !== po);
            end
         end
         if (s_stall) begin
            total++;
            if (!bus.sum_vld || s !== ps) begin
               bad++;
               $display("FAIL sum_hold: cycle %0d vld=%b rec=%h, required held %h", cyc, bus.sum_vld, s, ps);
            end
         end
         o_stall = bus.out_axis_tvalid && !bus.out_axis_tready; po = o;
         s_stall = bus.sum_vld && !bus.sum_rdy; ps = s;
         if (bus.out_axis_tvalid && bus.out_axis_tready) begin got_out.push_back(o); out_cyc.push_back(cyc); end
         if (bus.sum_vld && bus.sum_rdy) begin got_sum.push_back(s); sum_cyc.push_back(cyc); end
         if (bus.in_axis_tvalid && !bus.in_axis_tready && bus.sum_vld && !bus.sum_rdy) stall_seen = 1'b1;
         in_pend = bus.in_axis_tvalid && !bus.in_axis_tready;
         if (bus.in_axis_tvalid && bus.in_axis_tready) begin
            in_q.pop_front(); in_cyc.push_back(cyc);
         end
         if (in_q.size() == 0 && !bus.out_axis_tvalid && !bus.sum_vld) idle++;
         else idle = 0;
         cyc++; n++;
      end
      total++;
      if (idle < 3) begin
         bad++;
         $display("FAIL run_timeout: %0d beats pending after %0d cycles, required drained", in_q.size(), n);
         in_q.delete();
      end
      bus.in_axis_tvalid = 1'b0;
   endtask

   task automatic check_out(input string tag);
      chk({tag, "_out_count"}, 64'(got_out.size()), 64'(exp_out.size()));
      for (int i = 0; i < got_out.size() && i < exp_out.size(); i++) begin
         total++;
         if (got_out[i] !== exp_out[i]) begin
            bad++;
            $display("FAIL %s_beat%0d: got tlast=%b qid=%h mdata=%h data=%h expected tlast=%b qid=%h mdata=%h data=%h",
                     tag, i, got_out[i].tlast, got_out[i].qid, got_out[i].mdata, got_out[i].data,
                     exp_out[i].tlast, exp_out[i].qid, exp_out[i].mdata, exp_out[i].data);
         end
      end
   endtask

   task automatic check_sum(input string tag);
      chk({tag, "_sum_count"}, 64'(got_sum.size()), 64'(exp_sum.size()));
      for (int i = 0; i < got_sum.size() && i < exp_sum.size(); i++)
         chk({tag, "_sum_rec"}, 64'(got_sum[i]), 64'(exp_sum[i]));
   endtask

   initial begin
      tbl[0] = '{11'h005, 32'hABCD1234, 4, 0, 0, 16'd4, 1'b0};
      tbl[1] = '{11'h005, 32'hABCD1234, 4, 0, 1, 16'd4, 1'b0};
      tbl[2] = '{11'h3A7, 32'h1234_5678, 0, 0, 0, 16'd0, 1'b1};
      tbl[3] = '{11'h041, 32'hCAFE_F00D, 3, 1, 0, 16'd3, CHK};
      tbl[4] = '{11'h2FF, 32'h0BAD_BEEF, 5, 2, 2, 16'd5, 1'b1};
      tbl[5] = '{11'h7FF, 32'hFFFF_0001, 1, 0, 0, 16'd1, 1'b0};

      bus.in_axis_tvalid = 1'b0; bus.in_axis_tdata = '0; bus.in_axis_tdest = '0;
      bus.in_axis_tuser = 1'b0; bus.in_axis_tlast = 1'b0;
      bus.out_axis_tready = 1'b0; bus.sum_rdy = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      chk("rst_out_tvalid", 64'(bus.out_axis_tvalid), 64'd0);
      chk("rst_out_tlast", 64'(bus.out_axis_tlast), 64'd0);
      chk("rst_out_qid", 64'(bus.out_axis_qid), 64'd0);
      chk("rst_out_mdata", 64'(bus.out_axis_mdata), 64'd0);
      chk("rst_out_tdata_zero", 64'(bus.out_axis_tdata == '0), 64'd1);
      chk("rst_sum_vld", 64'(bus.sum_vld), 64'd0);
      chk("rst_sum_rec", 64'({bus.sum_qid, bus.sum_beats, bus.sum_err}), 64'd0);
      chk("rst_drop_cnt", 64'(bus.drop_cnt), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // stray payload beats before any header are dropped
      for (int i = 0; i < 3; i++) push_beat('{rand_data(), 1'b0, (i == 2), 16'h0000});
      run(100);
      chk("drop_cnt_3", 64'(bus.drop_cnt), 64'd3);
      chk("drop_no_out", 64'(got_out.size()), 64'd0);
      chk("drop_no_sum", 64'(got_sum.size()), 64'd0);

      // partial packet cut short by reset
      clear_all();
      push_beat('{rand_data() & ~DW'(64'hFFFF_FFFF_FFFF_FFFF) | DW'(64'h5555_5555_0000_0123), 1'b1, 1'b0, 16'h0023});
      push_beat('{rand_data(), 1'b0, 1'b0, 16'h0023});
      push_beat('{rand_data(), 1'b0, 1'b0, 16'h0023});
      run(100);
      check_out("partial");
      chk("partial_no_sum", 64'(got_sum.size()), 64'd0);
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      chk("midrst_out_tvalid", 64'(bus.out_axis_tvalid), 64'd0);
      chk("midrst_sum_vld", 64'(bus.sum_vld), 64'd0);
      chk("midrst_drop_cnt", 64'(bus.drop_cnt), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      m_in_pkt = 1'b0; m_drops = 0;

      for (int t = 0; t < 6; t++) begin
         clear_all();
         ordy_mode = tbl[t].ordy_mode; srdy_mode = 0; vld_gap = 1'b0;
         add_pkt(tbl[t].qid, tbl[t].mdata, tbl[t].npld, tbl[t].pld_mode);
         run(500);
         check_out($sformatf("vec%0d", t));
         chk($sformatf("vec%0d_sum_count", t), 64'(got_sum.size()), 64'd1);
         if (got_sum.size() > 0) begin
            chk($sformatf("vec%0d_sum_qid", t), 64'(got_sum[0].qid), 64'(tbl[t].qid));
            chk($sformatf("vec%0d_sum_beats", t), 64'(got_sum[0].beats), 64'(tbl[t].exp_beats));
            chk($sformatf("vec%0d_sum_err", t), 64'(got_sum[0].err), 64'(tbl[t].exp_err));
         end
         if (tbl[t].ordy_mode == 0 && tbl[t].npld > 0 && out_cyc.size() == tbl[t].npld
             && in_cyc.size() == tbl[t].npld + 1 && sum_cyc.size() == 1) begin
            chk($sformatf("vec%0d_latency", t), 64'(out_cyc[0] - in_cyc[1]), 64'd1);
            chk($sformatf("vec%0d_no_bubble", t), 64'(out_cyc[tbl[t].npld-1] - out_cyc[0]), 64'(tbl[t].npld - 1));
            chk($sformatf("vec%0d_sum_with_tlast", t), 64'(sum_cyc[0]), 64'(out_cyc[tbl[t].npld-1]));
         end
      end
      chk("tbl_drop_cnt", 64'(bus.drop_cnt), 64'd0);

      // summary slot held full: second 1-beat packet's last beat must wait for sum_rdy
      clear_all();
      ordy_mode = 0; srdy_mode = 3; srdy_hold = 12; stall_seen = 1'b0;
      add_pkt(11'h011, 32'h1111_0000, 1, 0);
      add_pkt(11'h022, 32'h2222_0000, 1, 0);
      run(300);
      chk("sumstall_seen", 64'(stall_seen), 64'd1);
      if (in_cyc.size() == 4) chk("sumstall_accept_cycle", 64'(in_cyc[3] - run_base), 64'd12);
      else chk("sumstall_accept_count", 64'(in_cyc.size()), 64'd4);
      check_out("sumstall");
      chk("sumstall_count", 64'(got_sum.size()), 64'd2);
      if (got_sum.size() == 2) begin
         chk("sumstall_first", 64'(got_sum[0]), 64'({11'h011, 16'd1, 1'b0}));
         chk("sumstall_second", 64'(got_sum[1]), 64'({11'h022, 16'd1, 1'b0}));
      end

      // randomized traffic with random backpressure and valid gaps
      clear_all();
      ordy_mode = 2; srdy_mode = 2; vld_gap = 1'b1;
      for (int p = 0; p < 40; p++) begin
         if ($urandom_range(0, 5) == 0)
            for (int k = 0; k < $urandom_range(1, 2); k++)
               push_beat('{rand_data(), 1'b0, 1'($urandom_range(0, 1)), 16'($urandom())});
         add_pkt(QW'($urandom_range(0, 2047)), $urandom(), $urandom_range(0, 6), $urandom_range(0, 5) % 3);
      end
      run(20000);
      check_out("rand");
      check_sum("rand");
      chk("rand_drop_cnt", 64'(bus.drop_cnt), 64'(m_drops));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
